// File: rtl/intr_unit_pkg.sv
// intr_unit_pkg: shared address type, interrupt vector and interrupt FSM states.
package intr_unit_pkg;
  localparam int ADDR_W = 16;
  typedef logic [ADDR_W-1:0] addr_t;
  localparam addr_t INT_VECTOR = 16'h0040;
  typedef enum logic [1:0] {IDLE, ACK, ISR, RET} intr_state_t;
  function automatic logic en_update(input logic cur, input logic ei, input logic di);
    return (ei ^ di) ? ei : cur;
  endfunction
endpackage

// File: rtl/intr_unit.sv
// intr_unit: single-level interrupt controller with global enable, per-button mask and PC redirect.
module intr_unit
  import intr_unit_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       irq,
  input  logic       boundary,
  input  addr_t      pc_next,
  input  logic       reti,
  input  logic       ei,
  input  logic       di,
  input  logic       ie_wr,
  input  logic [3:0] ie_wdata,
  output logic [3:0] ie,
  output logic       ack,
  output logic       take,
  output addr_t      target,
  output logic       in_isr
);
  intr_state_t state, state_nx;
  logic irq_q, gie, gie_nx, gie_saved, gie_saved_nx;
  addr_t saved_pc;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      gie       <= 1'b0;
      gie_saved <= 1'b0;
      ie        <= '0;
      irq_q     <= 1'b0;
      saved_pc  <= '0;
    end else begin
      state     <= state_nx;
      gie       <= gie_nx;
      gie_saved <= gie_saved_nx;
      ie        <= ie_wr ? ie_wdata : ie;
      irq_q     <= irq;
      saved_pc  <= (state == ACK) ? pc_next : saved_pc;
    end
  end
  // ei/di act on the live enable outside service and on the saved copy inside it
  always_comb begin
    state_nx     = state;
    gie_nx       = gie;
    gie_saved_nx = gie_saved;
    ack          = 1'b0;
    take         = 1'b0;
    target       = '0;
    in_isr       = 1'b0;
    case (state)
      IDLE: begin
        gie_nx   = en_update(gie, ei, di);
        state_nx = (irq_q && gie && boundary) ? ACK : IDLE;
      end
      ACK: begin
        ack          = 1'b1;
        take         = 1'b1;
        target       = INT_VECTOR;
        gie_saved_nx = gie;
        gie_nx       = 1'b0;
        state_nx     = ISR;
      end
      ISR: begin
        in_isr       = 1'b1;
        gie_saved_nx = en_update(gie_saved, ei, di);
        state_nx     = reti ? RET : ISR;
      end
      default: begin
        take     = 1'b1;
        target   = saved_pc;
        gie_nx   = gie_saved;
        state_nx = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_intr_unit.sv
// tb_intr_unit: directed stimulus with a scoreboard of expected take/ack events checked by a monitor.
module tb_intr_unit;
  import intr_unit_pkg::*;
  logic clock = 1'b0, reset, irq, boundary, reti, ei, di, ie_wr;
  logic [3:0] ie_wdata, ie;
  logic ack, take, in_isr;
  addr_t pc_next, target;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int cyc; logic ack; addr_t tgt;} exp_t;
  exp_t sb[$];

  intr_unit dut (
    .clock(clock), .reset(reset), .irq(irq), .boundary(boundary), .pc_next(pc_next),
    .reti(reti), .ei(ei), .di(di), .ie_wr(ie_wr), .ie_wdata(ie_wdata), .ie(ie),
    .ack(ack), .take(take), .target(target), .in_isr(in_isr)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic a, input addr_t t);
    sb.push_back('{cyc: c, ack: a, tgt: t});
  endtask

  always @(negedge clock) begin
    if (take) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_take: got ack=%0b target=%0h at cycle %0d, expected no take", ack, target, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.ack !== ack || e.tgt !== target) begin
          fails++;
          $display("FAIL take_event: got cycle=%0d ack=%0b target=%0h expected cycle=%0d ack=%0b target=%0h",
                   cyc, ack, target, e.cyc, e.ack, e.tgt);
        end
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_take: got no take by cycle %0d expected ack=%0b target=%0h at cycle %0d",
               cyc, e.ack, e.tgt, e.cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    reset = 0; irq = 0; boundary = 0; pc_next = '0; reti = 0;
    ei = 0; di = 0; ie_wr = 0; ie_wdata = '0;
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_take", take, 0);
    chk("rst_target", target, 0);
    chk("rst_in_isr", in_isr, 0);
    chk("rst_ie", ie, 0);
    chk("rst_gie", dut.gie, 0);
    reset = 1;
    // mask write, enable and button press, then take at the first boundary
    ie_wr = 1; ie_wdata = 4'b0101; ei = 1; irq = 1; pc_next = 16'd5;
    tick();
    ie_wr = 0; ei = 0;
    chk("ie_write", ie, 4'b0101);
    boundary = 1; push(cyc + 1, 1, INT_VECTOR);
    tick();
    boundary = 0; irq = 0;
    tick();
    chk("isr_in_isr", in_isr, 1);
    chk("isr_gie_cleared", dut.gie, 0);
    repeat (2) tick();
    reti = 1; push(cyc + 1, 0, 16'd5);
    tick();
    reti = 0;
    tick();
    chk("ret_idle", dut.state, IDLE);
    chk("ret_gie", dut.gie, 1);
    chk("ret_in_isr", in_isr, 0);
    reti = 1;
    tick();
    reti = 0;
    chk("reti_idle_ignored", dut.state, IDLE);
    // a request that drops before any boundary is lost
    irq = 1; tick();
    irq = 0; tick();
    boundary = 1; repeat (2) tick();
    boundary = 0;
    chk("glitch_no_ack", dut.state, IDLE);
    // request held while disabled stays pending until ei
    di = 1; tick();
    di = 0;
    chk("di_clears_gie", dut.gie, 0);
    irq = 1;
    for (int i = 0; i < 10; i++) begin
      boundary = (i % 3 == 2);
      tick();
    end
    boundary = 0;
    chk("pend_no_ack", dut.state, IDLE);
    ei = 1; tick();
    ei = 0;
    chk("ei_sets_gie", dut.gie, 1);
    pc_next = 16'h0123; boundary = 1; push(cyc + 1, 1, INT_VECTOR);
    tick();
    boundary = 0; irq = 0;
    tick();
    // second request during service waits for RET, then is taken at once
    irq = 1; boundary = 1;
    repeat (4) tick();
    chk("no_nest", in_isr, 1);
    reti = 1; push(cyc + 1, 0, 16'h0123); push(cyc + 3, 1, INT_VECTOR);
    tick();
    reti = 0;
    repeat (2) tick();
    boundary = 0; irq = 0; ie_wr = 1; ie_wdata = 4'b1010;
    chk("ack_ie_prewrite", ie, 4'b0101);
    tick();
    ie_wr = 0;
    chk("ie_written_in_ack", ie, 4'b1010);
    di = 1; tick();
    di = 0;
    chk("isr_di_keeps_gie", dut.gie, 0);
    reti = 1; push(cyc + 1, 0, 16'h0123);
    tick();
    reti = 0;
    tick();
    chk("ret_restores_di", dut.gie, 0);
    // simultaneous ei/di leave the enable alone
    ei = 1; tick();
    ei = 0; di = 0;
    ei = 1; di = 1; irq = 1;
    tick();
    ei = 0; di = 0;
    chk("ei_di_hold", dut.gie, 1);
    boundary = 1; push(cyc + 1, 1, INT_VECTOR);
    tick();
    boundary = 0; irq = 0;
    // reset during the ACK cycle
    reset = 0;
    tick();
    chk("rstack_ack", ack, 0);
    chk("rstack_take", take, 0);
    chk("rstack_target", target, 0);
    chk("rstack_in_isr", in_isr, 0);
    chk("rstack_ie", ie, 0);
    chk("rstack_state", dut.state, IDLE);
    reset = 1;
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/intr_unit.md
INTR_UNIT -- requirements
Module: intr_unit

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port irq, input, 1, shared interrupt request from the button daisy chain.
REQ-004 SHALL have port boundary, input, 1, high in the last cycle of a CPU instruction.
REQ-005 SHALL have port pc_next, input, addr_t, address of the next sequential instruction.
REQ-006 SHALL have port reti, input, 1, return-from-interrupt instruction retiring this cycle.
REQ-007 SHALL have ports ei and di, input, 1 each, set and clear the global enable.
REQ-008 SHALL have ports ie_wr (input, 1) and ie_wdata (input, 4 bits); together they write the per-source mask.
REQ-009 SHALL have port ie, output, 4 bits, per-button enable mask driven to the buttons.
REQ-010 SHALL have port ack, output, 1, one-cycle acknowledge pulse to the daisy chain.
REQ-011 SHALL have port take, output, 1, CPU must load target as its PC this cycle.
REQ-012 SHALL have port target, output, addr_t, PC redirect address.
REQ-013 SHALL have port in_isr, output, 1, high while an interrupt is being serviced.

Function
REQ-014 SHALL register irq into irq_q every cycle; decisions use irq_q only.
REQ-015 SHALL implement the FSM IDLE, ACK, ISR, RET.
REQ-016 IDLE->ACK SHALL occur when irq_q=1, gie=1 and boundary=1 in the same cycle; otherwise stay in IDLE.
REQ-017 ACK SHALL last exactly one cycle, with ack=1, take=1 and target=INT_VECTOR.
REQ-018 In ACK, the unit SHALL save saved_pc<=pc_next and gie_saved<=gie, clear gie, then go to ISR.
REQ-019 In ISR, in_isr SHALL be 1 and reti=1 SHALL cause ISR->RET; irq_q SHALL be ignored (no nesting).
REQ-020 RET SHALL last one cycle, with take=1, target=saved_pc and gie<=gie_saved, then go to IDLE.
REQ-021 Latency: the ACK cycle SHALL be the cycle immediately after the qualifying IDLE cycle.
REQ-022 Worst case from irq rising to ack SHALL be 2 cycles plus the wait for boundary.
REQ-023 ack and take SHALL be 0 in IDLE and ISR; target SHALL be 0 when take=0.
REQ-024 reti in IDLE, ACK or RET SHALL be ignored.
REQ-025 ei and di together SHALL leave gie unchanged.
REQ-026 ei or di in ACK SHALL be ignored; in ISR they SHALL update gie_saved instead of gie.
REQ-027 ie_wr SHALL write ie<=ie_wdata on the next edge in any state, including ACK.
REQ-028 The ie value driven during ACK SHALL be the pre-write value.
REQ-029 irq_q=1 with gie=0 SHALL stay pending without loss; it is taken at the first boundary after ei.
REQ-030 irq deasserting before boundary SHALL cause no ACK.

Reset
REQ-031 reset=0 at a clock edge SHALL force state=IDLE, gie=0, gie_saved=0, ie=4'b0000, irq_q=0 and saved_pc=0.
REQ-032 Reset SHALL also force ack=0, take=0, target=0 and in_isr=0 from the same edge.
REQ-033 Reset asserted in any state, including mid-ACK or mid-ISR, SHALL abort without emitting ack or take.

Structure
REQ-034 addr_t and INT_VECTOR SHALL live in the shared types package.
REQ-035 The FSM state enum intr_state_t SHALL live in the shared types package.
REQ-036 The unit SHALL be a single flat module; no sub-module.
REQ-037 The cpu SHALL instantiate intr_unit, replacing its internal ie, irq and ack logic.

Verification
REQ-038 Scenario: ie_wr=1 with ie_wdata=4'b0101, ei=1, button0 pressed -> one-cycle ack, take=1 with target=INT_VECTOR at the first boundary+1, and in_isr=1.
REQ-039 Scenario: in ISR with pc_next=5 saved, reti=1 -> the next cycle has take=1 and target=5, then IDLE with gie=1.
REQ-040 Scenario: irq held while gie=0 for 10 cycles, then ei -> no ack before ei; ack one cycle after the next boundary.
REQ-041 Scenario: second irq during ISR -> no ack until after RET, then a second ACK at the next boundary.
REQ-042 Scenario: reset=0 asserted in the ACK cycle -> all outputs 0 on the following cycle, ie=0 and state IDLE.
REQ-043 Scenario: ei and di both set in the same IDLE cycle with gie=1 -> gie stays 1; pending irq is taken normally.
